// File: rtl/addsub_accum.sv
// addsub_accum: two-stage add/subtract unit with an accumulator,
// optional saturation and per-result plus sticky overflow flags.
module addsub_accum #(
  parameter int WIDTH    = 6,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clr_sticky,
  input  logic             clr_acc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_Val,
  output logic             nA_LED,
  output logic             nB_LED,
  output logic             nR_LED,
  output logic             over_LED,
  output logic             sticky_over_LED
);

  localparam int W1 = WIDTH + 1;

  localparam logic [WIDTH-1:0] MAX_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  s1_t  s1;
  logic s1_valid;

  logic          acc_op;
  logic          sub_op;
  logic [W1-1:0] lhs;
  logic [W1-1:0] rhs;
  logic [W1-1:0] rhs_x;
  logic [W1-1:0] sum;
  logic          ovf;
  logic [WIDTH-1:0] res;

  // Capture stage: operands hold while no new op is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.op <= op;
        s1.a  <= A;
        s1.b  <= B;
      end
    end
  end

  // Execute datapath: one WIDTH+1 adder, subtract as ~x + 1.
  always_comb begin
    acc_op = 1'b0;
    sub_op = 1'b0;
    unique case (s1.op)
      2'b00: begin acc_op = 1'b0; sub_op = 1'b0; end
      2'b01: begin acc_op = 1'b0; sub_op = 1'b1; end
      2'b10: begin acc_op = 1'b1; sub_op = 1'b0; end
      2'b11: begin acc_op = 1'b1; sub_op = 1'b1; end
      default: begin acc_op = 1'b0; sub_op = 1'b0; end
    endcase
    lhs = acc_op ? {out_Val[WIDTH-1], out_Val}
                 : {s1.a[WIDTH-1], s1.a};
    rhs = acc_op ? {s1.a[WIDTH-1], s1.a}
                 : {s1.b[WIDTH-1], s1.b};
    rhs_x = sub_op ? ~rhs : rhs;
    sum   = lhs + rhs_x + {{WIDTH{1'b0}}, sub_op};
    ovf   = sum[WIDTH] ^ sum[WIDTH-1];
    res   = sum[WIDTH-1:0];
    if (SATURATE != 0 && ovf) begin
      res = sum[WIDTH] ? MAX_NEG : MAX_POS;
    end
  end

  // Result register; an execute beats a same-cycle accumulator clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_Val   <= '0;
      nA_LED    <= 1'b0;
      nB_LED    <= 1'b0;
      nR_LED    <= 1'b0;
      over_LED  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_Val  <= res;
        over_LED <= ovf;
        nR_LED   <= res[WIDTH-1];
        nA_LED   <= s1.a[WIDTH-1];
        nB_LED   <= ~acc_op & s1.b[WIDTH-1];
      end else if (clr_acc) begin
        out_Val <= '0;
        nR_LED  <= 1'b0;
      end
    end
  end

  // Sticky overflow; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_over_LED <= 1'b0;
    end else if (s1_valid && ovf) begin
      sticky_over_LED <= 1'b1;
    end else if (clr_sticky) begin
      sticky_over_LED <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// tb_addsub_accum: wrap and saturating instances side by side,
// table vectors, directed sequences and a random run vs a model.
module tb_addsub_accum;

  localparam int W    = 6;
  localparam int MAXV = 31;
  localparam int MINV = -32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clr_sticky;
  logic         clr_acc;

  logic         ov0, ov1;
  logic [W-1:0] val0, val1;
  logic         na0, na1, nb0, nb1, nr0, nr1;
  logic         over0, over1, st0, st1;

  always #5 clk = ~clk;

  addsub_accum #(.WIDTH(W), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .op(op), .A(a), .B(b),
    .clr_sticky(clr_sticky), .clr_acc(clr_acc),
    .out_valid(ov0), .out_Val(val0),
    .nA_LED(na0), .nB_LED(nb0), .nR_LED(nr0),
    .over_LED(over0), .sticky_over_LED(st0)
  );

  addsub_accum #(.WIDTH(W), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .op(op), .A(a), .B(b),
    .clr_sticky(clr_sticky), .clr_acc(clr_acc),
    .out_valid(ov1), .out_Val(val1),
    .nA_LED(na1), .nB_LED(nb1), .nR_LED(nr1),
    .over_LED(over1), .sticky_over_LED(st1)
  );

  int checks = 0;
  int errors = 0;

  // reference model: integer values, one pending op
  bit m_valid;
  int m_acc    [2];
  bit m_over   [2];
  bit m_sticky [2];
  bit m_na     [2];
  bit m_nb     [2];
  bit p_valid;
  int p_op, p_a, p_b;

  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    int         e0;
    int         e1;
    bit         ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name,
                       input logic [31:0] got_v,
                       input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, got_v, exp_v);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    int r;
    r = int'(v);
    if (v[W-1]) r = r - (1 << W);
    return r;
  endfunction

  function automatic void calc(input int opv, input int av,
                               input int bv, input int acc,
                               input bit sat, output int res,
                               output bit ovf);
    int t;
    logic [31:0] u;
    case (opv)
      0:       t = av + bv;
      1:       t = av - bv;
      2:       t = acc + av;
      default: t = acc - av;
    endcase
    ovf = (t > MAXV) || (t < MINV);
    if (ovf && sat) begin
      res = (t > 0) ? MAXV : MINV;
    end else begin
      u   = t;
      res = sx(u[W-1:0]);
    end
  endfunction

  task automatic model_edge();
    int r;
    bit o;
    if (reset) begin
      m_valid = 0;
      p_valid = 0;
      p_op = 0; p_a = 0; p_b = 0;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_over[i] = 0; m_sticky[i] = 0;
        m_na[i] = 0; m_nb[i] = 0;
      end
    end else begin
      m_valid = p_valid;
      for (int i = 0; i < 2; i++) begin
        if (p_valid) begin
          calc(p_op, p_a, p_b, m_acc[i], i == 1, r, o);
          m_acc[i]  = r;
          m_over[i] = o;
          m_na[i]   = p_a < 0;
          m_nb[i]   = (p_op < 2) && (p_b < 0);
          if (o) m_sticky[i] = 1;
          else if (clr_sticky) m_sticky[i] = 0;
        end else begin
          if (clr_acc) m_acc[i] = 0;
          if (clr_sticky) m_sticky[i] = 0;
        end
      end
      p_valid = in_valid;
      if (in_valid) begin
        p_op = int'(op);
        p_a  = sx(a);
        p_b  = sx(b);
      end
    end
  endtask

  function automatic logic [W+5:0] got(input int i);
    if (i == 0)
      return {ov0, val0, na0, nb0, nr0, over0, st0};
    return {ov1, val1, na1, nb1, nr1, over1, st1};
  endfunction

  function automatic logic [W+5:0] expv(input int i);
    logic [31:0] u;
    u = m_acc[i];
    return {m_valid, u[W-1:0], m_na[i], m_nb[i],
            m_acc[i] < 0, m_over[i], m_sticky[i]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("model dut%0d", i),
            32'(got(i)), 32'(expv(i)));
  endtask

  initial begin
    vecs[0] = '{2'd1,   5,   3,   2,   2, 1'b0};
    vecs[1] = '{2'd1,   3,   5,  -2,  -2, 1'b0};
    vecs[2] = '{2'd1,   5, -32, -27,  31, 1'b1};
    vecs[3] = '{2'd1, -32,   1,  31, -32, 1'b1};
    vecs[4] = '{2'd0,  31,   1, -32,  31, 1'b1};
    vecs[5] = '{2'd0, -32, -32,   0, -32, 1'b1};
    vecs[6] = '{2'd0,  -5,   7,   2,   2, 1'b0};
    vecs[7] = '{2'd1, -32, -32,   0,   0, 1'b0};
    vecs[8] = '{2'd1,   0, -32, -32,  31, 1'b1};

    reset = 1; in_valid = 1; op = 2'd1;
    a = 6'd5; b = 6'd3;
    clr_sticky = 0; clr_acc = 0;

    // reset held with in_valid high
    cycle();
    cycle();
    check("reset dut0", 32'(got(0)), 32'd0);
    check("reset dut1", 32'(got(1)), 32'd0);
    reset = 0; in_valid = 0;
    cycle();
    check("post reset valid0", 32'(ov0), 32'd0);
    check("post reset valid1", 32'(ov1), 32'd0);
    cycle();

    // table vectors: issue, then one idle cycle to the result
    for (int k = 0; k < 9; k++) begin
      in_valid = 1;
      op = vecs[k].op;
      a  = W'(vecs[k].a);
      b  = W'(vecs[k].b);
      cycle();
      in_valid = 0;
      cycle();
      check($sformatf("vec%0d valid", k), 32'(ov0), 32'd1);
      check($sformatf("vec%0d val0", k),
            32'(sx(val0)), 32'(vecs[k].e0));
      check($sformatf("vec%0d val1", k),
            32'(sx(val1)), 32'(vecs[k].e1));
      check($sformatf("vec%0d over0", k),
            32'(over0), 32'(vecs[k].ovf));
      check($sformatf("vec%0d over1", k),
            32'(over1), 32'(vecs[k].ovf));
      check($sformatf("vec%0d nR0", k),
            32'(nr0), 32'(vecs[k].e0 < 0));
      check($sformatf("vec%0d nA0", k),
            32'(na0), 32'(vecs[k].a < 0));
    end

    // accumulate chain
    clr_acc = 1;
    cycle();
    check("clr_acc val0", 32'(val0), 32'd0);
    check("clr_acc val1", 32'(val1), 32'd0);
    clr_acc = 0;
    in_valid = 1; op = 2'd2; a = 6'd20; b = 6'd0;
    cycle();
    cycle();
    check("acc1 val0", 32'(sx(val0)), 32'd20);
    check("acc1 val1", 32'(sx(val1)), 32'd20);
    cycle();
    in_valid = 0;
    check("acc2 val0", 32'(val0), 32'b101000);
    check("acc2 over0", 32'(over0), 32'd1);
    check("acc2 val1", 32'(sx(val1)), 32'd31);
    cycle();
    check("acc3 val0", 32'(sx(val0)), 32'(-4));
    check("acc3 over0", 32'(over0), 32'd0);
    check("acc3 sticky0", 32'(st0), 32'd1);
    check("acc3 val1", 32'(sx(val1)), 32'd31);
    check("acc3 nB0", 32'(nb0), 32'd0);

    // sticky: set wins over clear, then clear alone
    in_valid = 1; op = 2'd1; a = 6'd5; b = 6'b100000;
    cycle();
    in_valid = 0; clr_sticky = 1;
    cycle();
    check("set wins sticky0", 32'(st0), 32'd1);
    check("set wins sticky1", 32'(st1), 32'd1);
    cycle();
    clr_sticky = 0;
    check("clear sticky0", 32'(st0), 32'd0);
    check("clear sticky1", 32'(st1), 32'd0);

    // execute wins over clr_acc
    in_valid = 1; op = 2'd0; a = 6'd3; b = 6'd4;
    cycle();
    in_valid = 0; clr_acc = 1;
    cycle();
    clr_acc = 0;
    check("exec wins val0", 32'(val0), 32'd7);
    check("exec wins val1", 32'(val1), 32'd7);
    cycle();
    check("hold val0", 32'(val0), 32'd7);
    check("hold valid0", 32'(ov0), 32'd0);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 79) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      op         = 2'($urandom);
      a          = W'($urandom);
      b          = W'($urandom);
      if ($urandom_range(0, 5) == 0) a = 6'b100000;
      if ($urandom_range(0, 5) == 0) b = 6'b100000;
      clr_acc    = ($urandom_range(0, 7) == 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      cycle();
    end
    reset = 0; in_valid = 0;
    clr_acc = 0; clr_sticky = 0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
